// File: rtl/riscv_pipe_pkg.sv
// Shared RV32I pipeline definitions: datapath widths, writeback select
// encodings, load funct3 codes and the writeback slot record.
package riscv_pipe_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LOAD = 2'b01,
        WB_SEL_PC4  = 2'b10,
        WB_SEL_RSVD = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // One writeback entry: data is already selected and formatted.
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_slot_t;

endpackage

// File: rtl/wb_load_formatter.sv
// Combinational load-data formatter: extracts the addressed byte/halfword
// from an aligned memory word and sign- or zero-extends it.
module wb_load_formatter
    import riscv_pipe_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] raw_word,
    output logic [XLEN-1:0] fmt_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select, then extension by load type; halfword ignores offset[0].
    always_comb begin
        byte_sel = '0;
        half_sel = offset[1] ? raw_word[31:16] : raw_word[15:0];
        fmt_word = raw_word;
        case (offset)
            2'd0:    byte_sel = raw_word[7:0];
            2'd1:    byte_sel = raw_word[15:8];
            2'd2:    byte_sel = raw_word[23:16];
            default: byte_sel = raw_word[31:24];
        endcase
        case (funct3)
            F3_LB:   fmt_word = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   fmt_word = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   fmt_word = raw_word;
            F3_LBU:  fmt_word = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  fmt_word = {{(XLEN-16){1'b0}}, half_sel};
            default: fmt_word = raw_word;
        endcase
    end

endmodule

// File: rtl/wb_writeback_stage.sv
// RV32I writeback stage: valid/ready capture from MEM into a MAIN slot with a
// one-entry SKID slot, register-file write port, retired-instruction counter.
// Optional EX bypass outputs enabled by defining WB_FORWARD_EN; otherwise the
// Fwd_* ports are tied to zero.
module wb_writeback_stage
    import riscv_pipe_pkg::*;
(
    input  logic                  Clk_In,
    input  logic                  Rst_In,
    input  logic                  Valid_In,
    output logic                  Ready_Out,
    input  logic                  Flush_In,
    input  logic                  Wb_Hold_In,
    input  logic                  Reg_Write_flag_In,
    input  logic [REG_ADDR_W-1:0] Rd_Addr_In,
    input  logic [1:0]            Wb_Sel_In,
    input  logic [2:0]            Funct3_In,
    input  logic [XLEN-1:0]       Alu_Result_In,
    input  logic [XLEN-1:0]       Load_Data_In,
    input  logic [XLEN-1:0]       Pc_Plus4_In,
    output logic                  Reg_Write_flag_Out,
    output logic [REG_ADDR_W-1:0] RD_Addr_Out,
    output logic [XLEN-1:0]       RD_Data_Out,
    output logic [31:0]           Instret_Out,
    output logic                  Fwd_Valid_Out,
    output logic [REG_ADDR_W-1:0] Fwd_Addr_Out,
    output logic [XLEN-1:0]       Fwd_Data_Out
);

    wb_slot_t        main_q, main_d;
    wb_slot_t        skid_q, skid_d;
    wb_slot_t        in_slot;
    logic            ready_q, ready_d;
    logic [31:0]     instret_q;
    logic [XLEN-1:0] load_fmt;
    logic [XLEN-1:0] sel_data;
    logic            accept;
    logic            retire;

    wb_load_formatter u_load_fmt (
        .funct3   (Funct3_In),
        .offset   (Alu_Result_In[1:0]),
        .raw_word (Load_Data_In),
        .fmt_word (load_fmt)
    );

    // Writeback value select; the reserved encoding falls back to the ALU result.
    always_comb begin
        sel_data = Alu_Result_In;
        case (wb_sel_e'(Wb_Sel_In))
            WB_SEL_LOAD: sel_data = load_fmt;
            WB_SEL_PC4:  sel_data = Pc_Plus4_In;
            default:     sel_data = Alu_Result_In;
        endcase
    end

    assign accept  = Valid_In && ready_q && !Flush_In;
    assign retire  = main_q.valid && !Wb_Hold_In && !Flush_In;
    assign in_slot = '{valid: 1'b1, we: Reg_Write_flag_In, rd: Rd_Addr_In, data: sel_data};

    // Slot movement; Ready_Out is derived from SKID occupancy after the edge.
    // SKID full implies Ready_Out low, so a retire from a full SKID never
    // coincides with an accept and SKID simply empties.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (Flush_In) begin
            main_d = '0;
            skid_d = '0;
        end else if (retire) begin
            if (skid_q.valid) begin
                main_d = skid_q;
                skid_d = '0;
            end else if (accept) begin
                main_d = in_slot;
            end else begin
                main_d = '0;
            end
        end else if (accept) begin
            if (!main_q.valid) begin
                main_d = in_slot;
            end else begin
                skid_d = in_slot;
            end
        end
        ready_d = !skid_d.valid;
    end

    // State registers and retired-instruction counter.
    always_ff @(posedge Clk_In) begin
        if (Rst_In) begin
            main_q    <= '0;
            skid_q    <= '0;
            ready_q   <= 1'b1;
            instret_q <= '0;
        end else begin
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign Ready_Out          = ready_q;
    assign Instret_Out        = instret_q;
    assign Reg_Write_flag_Out = retire && main_q.we && (main_q.rd != '0);
    assign RD_Addr_Out        = main_q.valid ? main_q.rd   : '0;
    assign RD_Data_Out        = main_q.valid ? main_q.data : '0;

`ifdef WB_FORWARD_EN
    assign Fwd_Valid_Out = main_q.valid && main_q.we && (main_q.rd != '0);
    assign Fwd_Addr_Out  = main_q.valid ? main_q.rd   : '0;
    assign Fwd_Data_Out  = main_q.valid ? main_q.data : '0;
`else
    assign Fwd_Valid_Out = 1'b0;
    assign Fwd_Addr_Out  = '0;
    assign Fwd_Data_Out  = '0;
`endif

endmodule
